ofs_plat_axi_mem_sink_ram: RTL and testbench



---
 rtl/ofs_plat_axi_mem_sink_ram_pkg.sv | 58 +++++
 rtl/ofs_plat_axi_mem_if.sv | 31 +++
 rtl/ofs_plat_axi_mem_sink_ram_array.sv | 39 +++
 rtl/ofs_plat_axi_mem_sink_ram.sv | 189 ++++++++++++++++++
 tb/tb_ofs_plat_axi_mem_sink_ram.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_plat_axi_mem_sink_ram_pkg.sv
// Shared types and constants for the AXI memory sink RAM.
// Holds bus widths, AXI payload structs, FSM state enums, response and burst
// encodings, and small address helpers used by the top level.
package ofs_plat_axi_mem_sink_ram_pkg;

  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned USER_WIDTH = 4;
  localparam int unsigned SIZE_FULL  = $clog2(STRB_WIDTH);

  localparam logic [1:0] OKAY       = 2'b00;
  localparam logic [1:0] SLVERR     = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} t_wr_state;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} t_rd_state;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } t_axi_ax;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } t_axi_w;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
  } t_axi_b;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } t_axi_r;

  // Only full-width INCR bursts are serviced.
  function automatic logic legal_burst(input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_INCR) && (size == 3'(SIZE_FULL));
  endfunction

  // Byte address to bus-word address; callers truncate to the RAM index width.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] addr);
    return addr >> SIZE_FULL;
  endfunction

endpackage

// File: rtl/ofs_plat_axi_mem_if.sv
// AXI memory bus bundle. to_source is the sink-side view (responds to a source),
// to_sink is the source-side view.
interface ofs_plat_axi_mem_if;
  import ofs_plat_axi_mem_sink_ram_pkg::*;

  t_axi_ax aw;
  logic    awvalid;
  logic    awready;
  t_axi_w  w;
  logic    wvalid;
  logic    wready;
  t_axi_b  b;
  logic    bvalid;
  logic    bready;
  t_axi_ax ar;
  logic    arvalid;
  logic    arready;
  t_axi_r  r;
  logic    rvalid;
  logic    rready;

  modport to_source (
    input  aw, awvalid, w, wvalid, bready, ar, arvalid, rready,
    output awready, wready, b, bvalid, arready, r, rvalid
  );

  modport to_sink (
    output aw, awvalid, w, wvalid, bready, ar, arvalid, rready,
    input  awready, wready, b, bvalid, arready, r, rvalid
  );
endinterface

// File: rtl/ofs_plat_axi_mem_sink_ram_array.sv
// Simple-dual-port RAM: byte-enabled write port, synchronous read port with
// one cycle of latency. A read and write to the same index in one cycle
// returns the old contents.
//   clk                       clock
//   wr_en / wr_idx / wr_be / wr_data   write port
//   rd_en / rd_idx / rd_data           read port (rd_data holds when rd_en is low)
module ofs_plat_axi_mem_sink_ram_array #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]      rd_data
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
        if (wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Registered read; doubles as the R data hold register.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ofs_plat_axi_mem_sink_ram.sv
// AXI memory sink backed by an internal RAM. Independent write (AW/W/B) and
// read (AR/R) state machines share one simple-dual-port array. Illegal bursts
// are drained and answered with SLVERR without touching the RAM.
//   clk          clock (same as the bus clock)
//   reset_n      synchronous active-low reset
//   mem_source   AXI bus; drives awready, wready, b/bvalid, arready, r/rvalid
module ofs_plat_axi_mem_sink_ram
  import ofs_plat_axi_mem_sink_ram_pkg::*;
#(
  parameter int unsigned LOG2_DEPTH = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ofs_plat_axi_mem_if.to_source     mem_source
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  // Write path state
  t_wr_state               wr_state;
  logic                    awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]     b_id_q;
  logic [1:0]              b_resp_q;
  logic [LOG2_DEPTH-1:0]   w_idx;
  logic [7:0]              w_len, w_beat;
  logic                    w_legal, w_last_err;

  // Read path state
  t_rd_state               rd_state;
  logic                    arready_q, rvalid_q;
  logic [ID_WIDTH-1:0]     r_id_q;
  logic [1:0]              r_resp_q;
  logic                    r_last_q;
  logic [LOG2_DEPTH-1:0]   r_idx;
  logic [7:0]              r_len, r_beat;
  logic                    r_legal;

  logic                    ram_wr_en, ram_rd_en;
  logic [DATA_WIDTH-1:0]   ram_rd_data;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{mem_source.aw.addr, mem_source.ar.addr};

  assign ram_wr_en = (wr_state == W_DATA) && mem_source.wvalid && w_legal;
  assign ram_rd_en = (rd_state == R_FETCH);

  ofs_plat_axi_mem_sink_ram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_idx  (w_idx),
    .wr_be   (mem_source.w.strb),
    .wr_data (mem_source.w.data),
    .rd_en   (ram_rd_en),
    .rd_idx  (r_idx),
    .rd_data (ram_rd_data)
  );

  // Write FSM: accept AW, count beats to len+1, then hold B until bready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state   <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= OKAY;
      w_idx      <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_legal    <= 1'b0;
      w_last_err <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && mem_source.awvalid) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            b_id_q     <= mem_source.aw.id;
            w_idx      <= LOG2_DEPTH'(word_addr(mem_source.aw.addr));
            w_len      <= mem_source.aw.len;
            w_beat     <= '0;
            w_legal    <= legal_burst(mem_source.aw.size, mem_source.aw.burst);
            w_last_err <= 1'b0;
            wr_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (mem_source.wvalid) begin
            w_idx  <= w_idx + LOG2_DEPTH'(1);
            w_beat <= w_beat + 8'd1;
            // The beat count ends the burst; wlast only affects the response.
            if (w_beat == w_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              b_resp_q <= (w_legal && !w_last_err && mem_source.w.last) ? OKAY : SLVERR;
              wr_state <= W_RESP;
            end else if (mem_source.w.last) begin
              w_last_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (mem_source.bready) begin
            bvalid_q  <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= OKAY;
            awready_q <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: one RAM fetch per beat, then present the beat until rready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      r_id_q    <= '0;
      r_resp_q  <= OKAY;
      r_last_q  <= 1'b0;
      r_idx     <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_legal   <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && mem_source.arvalid) begin
            arready_q <= 1'b0;
            r_id_q    <= mem_source.ar.id;
            r_idx     <= LOG2_DEPTH'(word_addr(mem_source.ar.addr));
            r_len     <= mem_source.ar.len;
            r_beat    <= '0;
            r_legal   <= legal_burst(mem_source.ar.size, mem_source.ar.burst);
            rd_state  <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q <= 1'b1;
          r_resp_q <= r_legal ? OKAY : SLVERR;
          r_last_q <= (r_beat == r_len);
          rd_state <= R_SEND;
        end
        R_SEND: begin
          if (mem_source.rready) begin
            rvalid_q <= 1'b0;
            if (r_last_q) begin
              arready_q <= 1'b1;
              rd_state  <= R_IDLE;
            end else begin
              r_idx    <= r_idx + LOG2_DEPTH'(1);
              r_beat   <= r_beat + 8'd1;
              rd_state <= R_FETCH;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Bus outputs; R data comes straight from the RAM output register, zeroed
  // for illegal bursts.
  always_comb begin
    mem_source.awready = awready_q;
    mem_source.wready  = wready_q;
    mem_source.bvalid  = bvalid_q;
    mem_source.b       = '0;
    mem_source.b.id    = b_id_q;
    mem_source.b.resp  = b_resp_q;
    mem_source.arready = arready_q;
    mem_source.rvalid  = rvalid_q;
    mem_source.r       = '0;
    mem_source.r.id    = r_id_q;
    mem_source.r.data  = r_legal ? ram_rd_data : '0;
    mem_source.r.resp  = r_resp_q;
    mem_source.r.last  = r_last_q;
  end

endmodule

// File: tb/tb_ofs_plat_axi_mem_sink_ram.sv
// Self-checking bench for ofs_plat_axi_mem_sink_ram: random data against a
// word-array memory model, with directed legality, wlast, wrap and reset cases.
module tb_ofs_plat_axi_mem_sink_ram;
  import ofs_plat_axi_mem_sink_ram_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int TMO = 400;

  logic clk;
  logic reset_n;

  ofs_plat_axi_mem_if mem_if();

  ofs_plat_axi_mem_sink_ram #(.LOG2_DEPTH(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_source (mem_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] mdl_mem [DEPTH];
  logic [DATA_WIDTH-1:0] wd_q[$];
  logic [STRB_WIDTH-1:0] ws_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_WIDTH-1:0] rand_word();
    logic [DATA_WIDTH-1:0] v;
    for (int i = 0; i < int'(DATA_WIDTH / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [STRB_WIDTH-1:0] rand_strb();
    return {$urandom, $urandom};
  endfunction

  task automatic load_beats(input int n, input bit full_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back(rand_word());
      ws_q.push_back(full_strb ? {STRB_WIDTH{1'b1}} : rand_strb());
    end
  endtask

  // One write burst; last_beat is the 1-based beat carrying wlast (0 = never).
  task automatic axi_write(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int last_beat, input int bready_delay, input string name);
    int cnt;
    logic legal;
    logic [1:0] exp_resp;
    int idx;
    legal = (burst == 2'b01) && (size == 3'd6);
    exp_resp = (legal && last_beat == int'(len) + 1) ? 2'b00 : 2'b10;
    mem_if.aw.id = id;
    mem_if.aw.addr = addr;
    mem_if.aw.len = len;
    mem_if.aw.size = size;
    mem_if.aw.burst = burst;
    mem_if.awvalid = 1'b1;
    cnt = 0;
    while (mem_if.awready !== 1'b1 && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (cnt >= TMO) begin
      n_fail++;
      $display("FAIL %s aw_timeout: awready=%b, expected 1", name, mem_if.awready);
    end
    @(posedge clk); #1;
    mem_if.awvalid = 1'b0;
    n_checks++;
    if (mem_if.wready !== 1'b1 || mem_if.awready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s aw_accept: wready=%b awready=%b, expected 1 0", name, mem_if.wready, mem_if.awready);
    end
    for (int bt = 0; bt <= int'(len); bt++) begin
      mem_if.w.data = wd_q[bt];
      mem_if.w.strb = ws_q[bt];
      mem_if.w.last = (bt + 1 == last_beat);
      mem_if.wvalid = 1'b1;
      cnt = 0;
      while (mem_if.wready !== 1'b1 && cnt < TMO) begin @(posedge clk); #1; cnt++; end
      if (cnt >= TMO) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s w_timeout beat %0d: wready=%b, expected 1", name, bt, mem_if.wready);
      end
      @(posedge clk); #1;
    end
    mem_if.wvalid = 1'b0;
    mem_if.w.last = 1'b0;
    n_checks++;
    if (mem_if.bvalid !== 1'b1 || mem_if.wready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s b_latency: bvalid=%b wready=%b, expected 1 0", name, mem_if.bvalid, mem_if.wready);
    end
    if (legal) begin
      for (int bt = 0; bt <= int'(len); bt++) begin
        idx = int'((addr >> 6) + 64'(bt)) % int'(DEPTH);
        for (int k = 0; k < int'(STRB_WIDTH); k++)
          if (ws_q[bt][k]) mdl_mem[idx][k*8 +: 8] = wd_q[bt][k*8 +: 8];
      end
    end
    for (int i = 0; i < bready_delay; i++) begin
      n_checks++;
      if (mem_if.bvalid !== 1'b1 || mem_if.b.id !== id || mem_if.b.resp !== exp_resp || mem_if.b.user !== '0) begin
        n_fail++;
        $display("FAIL %s b_hold cycle %0d: bvalid=%b id=%0h resp=%0h, expected 1 %0h %0h",
                 name, i, mem_if.bvalid, mem_if.b.id, mem_if.b.resp, id, exp_resp);
      end
      @(posedge clk); #1;
    end
    mem_if.bready = 1'b1;
    n_checks++;
    if (mem_if.bvalid !== 1'b1 || mem_if.b.id !== id || mem_if.b.resp !== exp_resp || mem_if.b.user !== '0) begin
      n_fail++;
      $display("FAIL %s b_resp: bvalid=%b id=%0h resp=%0h user=%0h, expected 1 %0h %0h 0",
               name, mem_if.bvalid, mem_if.b.id, mem_if.b.resp, mem_if.b.user, id, exp_resp);
    end
    @(posedge clk); #1;
    mem_if.bready = 1'b0;
    n_checks++;
    if (mem_if.bvalid !== 1'b0 || mem_if.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s b_done: bvalid=%b awready=%b, expected 0 1", name, mem_if.bvalid, mem_if.awready);
    end
  endtask

  // One read burst checked against the model; toggle randomizes rready.
  task automatic axi_read(input logic [ID_WIDTH-1:0] id, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input bit toggle, input string name);
    int cnt, beat, cyc, first;
    bit hold;
    t_axi_r held;
    logic legal;
    logic [1:0] exp_resp;
    logic [DATA_WIDTH-1:0] exp_data;
    int idx0;
    legal = (burst == 2'b01) && (size == 3'd6);
    exp_resp = legal ? 2'b00 : 2'b10;
    idx0 = int'(addr >> 6) % int'(DEPTH);
    mem_if.ar.id = id;
    mem_if.ar.addr = addr;
    mem_if.ar.len = len;
    mem_if.ar.size = size;
    mem_if.ar.burst = burst;
    mem_if.arvalid = 1'b1;
    cnt = 0;
    while (mem_if.arready !== 1'b1 && cnt < TMO) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (cnt >= TMO) begin
      n_fail++;
      $display("FAIL %s ar_timeout: arready=%b, expected 1", name, mem_if.arready);
    end
    @(posedge clk); #1;
    mem_if.arvalid = 1'b0;
    n_checks++;
    if (mem_if.arready !== 1'b0 || mem_if.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ar_accept: arready=%b rvalid=%b, expected 0 0", name, mem_if.arready, mem_if.rvalid);
    end
    beat = 0; cyc = 0; first = -1; hold = 1'b0; held = '0;
    while (beat <= int'(len) && cyc < TMO) begin
      mem_if.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        n_checks++;
        if (mem_if.rvalid !== 1'b1 || mem_if.r !== held) begin
          n_fail++;
          $display("FAIL %s r_hold beat %0d: rvalid=%b id=%0h last=%b, expected 1 %0h %b",
                   name, beat, mem_if.rvalid, mem_if.r.id, mem_if.r.last, held.id, held.last);
        end
      end
      if (mem_if.rvalid === 1'b1) begin
        if (first < 0) first = cyc;
        exp_data = legal ? mdl_mem[(idx0 + beat) % int'(DEPTH)] : '0;
        n_checks++;
        if (mem_if.r.data !== exp_data || mem_if.r.id !== id || mem_if.r.resp !== exp_resp ||
            mem_if.r.last !== (beat == int'(len)) || mem_if.r.user !== '0) begin
          n_fail++;
          $display("FAIL %s r_beat %0d: id=%0h resp=%0h last=%b data=%h, expected %0h %0h %b %h",
                   name, beat, mem_if.r.id, mem_if.r.resp, mem_if.r.last, mem_if.r.data,
                   id, exp_resp, (beat == int'(len)), exp_data);
        end
        hold = !mem_if.rready;
        held = mem_if.r;
        if (mem_if.rready) beat++;
      end else begin
        hold = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_if.rready = 1'b0;
    n_checks++;
    if (beat != int'(len) + 1) begin
      n_fail++;
      $display("FAIL %s r_count: %0d beats, expected %0d", name, beat, int'(len) + 1);
    end
    n_checks++;
    if (first != 1) begin
      n_fail++;
      $display("FAIL %s r_latency: first rvalid %0d cycles after accept, expected 1", name, first);
    end
    if (!toggle) begin
      n_checks++;
      if (cyc != 2 * int'(len) + 2) begin
        n_fail++;
        $display("FAIL %s r_throughput: %0d cycles, expected %0d", name, cyc, 2 * int'(len) + 2);
      end
    end
    n_checks++;
    if (mem_if.arready !== 1'b1 || mem_if.rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s r_done: arready=%b rvalid=%b, expected 1 0", name, mem_if.arready, mem_if.rvalid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_if.awready, mem_if.wready, mem_if.bvalid, mem_if.arready, mem_if.rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: aw/w/b/ar/r=%b, expected 00000",
               {mem_if.awready, mem_if.wready, mem_if.bvalid, mem_if.arready, mem_if.rvalid});
    end
    n_checks++;
    if (mem_if.b !== '0 || mem_if.r !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: b=%h r.id=%0h r.resp=%0h, expected zero", mem_if.b, mem_if.r.id, mem_if.r.resp);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_if.awready !== 1'b1 || mem_if.arready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: awready=%b arready=%b, expected 1 1", mem_if.awready, mem_if.arready);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      load_beats(256, 1'b1);
      axi_write(4'(k), 64'(k * 256 * 64), 8'd255, 3'd6, 2'b01, 256, 0, "fill");
    end
    axi_read(4'd1, 64'd0, 8'd15, 3'd6, 2'b01, 1'b0, "fill_check");
  endtask

  task automatic test_legal_write_read();
    load_beats(4, 1'b1);
    for (int i = 0; i < 4; i++) wd_q[i] = DATA_WIDTH'(8'hA0 + i);
    axi_write(4'd5, 64'h100, 8'd3, 3'd6, 2'b01, 4, 0, "legal_wr");
    axi_read(4'd7, 64'h100, 8'd3, 3'd6, 2'b01, 1'b0, "legal_rd");
  endtask

  task automatic test_partial_strobe();
    logic [ADDR_WIDTH-1:0] a;
    logic [7:0] l;
    load_beats(1, 1'b1);
    wd_q[0] = DATA_WIDTH'(8'hFF);
    ws_q[0] = 64'h1;
    axi_write(4'd1, 64'h100, 8'd0, 3'd6, 2'b01, 1, 0, "strb_wr");
    axi_read(4'd2, 64'h100, 8'd0, 3'd6, 2'b01, 1'b0, "strb_rd");
    for (int n = 0; n < 4; n++) begin
      a = 64'($urandom_range(0, 1023)) << 6;
      l = 8'($urandom_range(0, 5));
      load_beats(int'(l) + 1, 1'b0);
      axi_write(4'($urandom), a, l, 3'd6, 2'b01, int'(l) + 1, 0, "rand_wr");
      axi_read(4'($urandom), a, l, 3'd6, 2'b01, 1'($urandom), "rand_rd");
    end
  endtask

  task automatic test_bad_burst();
    load_beats(2, 1'b1);
    axi_write(4'd2, 64'h100, 8'd1, 3'd6, 2'b00, 2, 0, "bad_fixed_wr");
    axi_read(4'd3, 64'h100, 8'd1, 3'd6, 2'b01, 1'b0, "bad_fixed_rd");
    load_beats(3, 1'b1);
    axi_write(4'd4, 64'h2000, 8'd2, 3'd5, 2'b01, 3, 0, "bad_size_wr");
    axi_read(4'd5, 64'h2000, 8'd2, 3'd6, 2'b01, 1'b0, "bad_size_chk");
    axi_read(4'd6, 64'h2000, 8'd2, 3'd5, 2'b01, 1'b0, "bad_size_rd");
  endtask

  task automatic test_wlast_errors();
    load_beats(3, 1'b1);
    axi_write(4'd8, 64'h3000, 8'd2, 3'd6, 2'b01, 2, 0, "wlast_early_wr");
    axi_read(4'd8, 64'h3000, 8'd2, 3'd6, 2'b01, 1'b0, "wlast_early_rd");
    load_beats(2, 1'b1);
    axi_write(4'd9, 64'h3400, 8'd1, 3'd6, 2'b01, 0, 0, "wlast_missing_wr");
    axi_read(4'd9, 64'h3400, 8'd1, 3'd6, 2'b01, 1'b0, "wlast_missing_rd");
  endtask

  task automatic test_backpressure_wrap();
    load_beats(4, 1'b1);
    axi_write(4'd9, 64'(1022) << 6, 8'd3, 3'd6, 2'b01, 4, 5, "wrap_wr_bp");
    axi_read(4'd10, 64'(1023) << 6, 8'd1, 3'd6, 2'b01, 1'b1, "wrap_rd");
    axi_read(4'd11, 64'(1022) << 6, 8'd3, 3'd6, 2'b01, 1'b1, "wrap_rd4");
  endtask

  task automatic test_reset_mid_read();
    int cnt;
    mem_if.ar.id = 4'd3;
    mem_if.ar.addr = 64'h8000;
    mem_if.ar.len = 8'd3;
    mem_if.ar.size = 3'd6;
    mem_if.ar.burst = 2'b01;
    mem_if.arvalid = 1'b1;
    mem_if.rready = 1'b0;
    @(posedge clk); #1;
    mem_if.arvalid = 1'b0;
    cnt = 0;
    while (mem_if.rvalid !== 1'b1 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (cnt >= 20) begin
      n_fail++;
      $display("FAIL rst_mid_rvalid: rvalid=%b, expected 1", mem_if.rvalid);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_if.rvalid !== 1'b0 || mem_if.arready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: rvalid=%b arready=%b, expected 0 0", mem_if.rvalid, mem_if.arready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_if.rready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_if.arready !== 1'b1 || mem_if.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_release: arready=%b awready=%b, expected 1 1", mem_if.arready, mem_if.awready);
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_if.rvalid !== 1'b0) cnt++;
      @(posedge clk); #1;
    end
    mem_if.rready = 1'b0;
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: %0d stale rvalid cycles, expected 0", cnt);
    end
    axi_read(4'd4, 64'h8000, 8'd3, 3'd6, 2'b01, 1'b0, "rst_ram_kept");
  endtask

  task automatic test_back_to_back();
    load_beats(8, 1'b0);
    fork
      axi_write(4'd12, 64'(200) << 6, 8'd7, 3'd6, 2'b01, 8, 2, "conc_wr");
      axi_read(4'd13, 64'(600) << 6, 8'd3, 3'd6, 2'b01, 1'b0, "conc_rd");
    join
    axi_read(4'd14, 64'(200) << 6, 8'd7, 3'd6, 2'b01, 1'b0, "conc_chk");
    for (int i = 0; i < 3; i++)
      axi_read(4'(i), 64'($urandom_range(0, 1023)) << 6, 8'd0, 3'd6, 2'b01, 1'b0, "b2b_rd");
  endtask

  initial begin
    reset_n = 1'b0;
    mem_if.aw = '0;
    mem_if.awvalid = 1'b0;
    mem_if.w = '0;
    mem_if.wvalid = 1'b0;
    mem_if.bready = 1'b0;
    mem_if.ar = '0;
    mem_if.arvalid = 1'b0;
    mem_if.rready = 1'b0;
    test_reset();
    test_fill();
    test_legal_write_read();
    test_partial_strobe();
    test_bad_burst();
    test_wlast_errors();
    test_backpressure_wrap();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
